// File: rtl/axi_arb_pkg.sv
// Shared state types, AXI encodings and pointer helper for the axi_rr_arbiter slice.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Successor of idx in a ring of n masters.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    if ((idx + 32'd1) >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: lowest requester at or above ptr, otherwise
// the lowest requester below ptr.
module axi_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int GNT_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GNT_W-1:0]       ptr,
  output logic                   valid,
  output logic [GNT_W-1:0]       idx
);

  logic             hi_hit_s;
  logic             lo_hit_s;
  logic [GNT_W-1:0] hi_idx_s;
  logic [GNT_W-1:0] lo_idx_s;

  // Scan downwards so the final hit in each half is its lowest index
  always_comb begin
    hi_hit_s = 1'b0;
    lo_hit_s = 1'b0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i] && (GNT_W'(i) >= ptr)) begin
        hi_hit_s = 1'b1;
        hi_idx_s = GNT_W'(i);
      end else if (req[i]) begin
        lo_hit_s = 1'b1;
        lo_idx_s = GNT_W'(i);
      end else begin
        hi_hit_s = hi_hit_s;
      end
    end
  end

  assign valid = hi_hit_s | lo_hit_s;
  assign idx   = hi_hit_s ? hi_idx_s : lo_idx_s;

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter, independent read and write paths, one transaction each.
// Optional build macro ARB_FIXED_PRIO_EN: pointers held at 0, strict priority to master 0.
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4,
  localparam int GNT_W      = $clog2(NUM_MASTERS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*ID_W-1:0]   m_arid,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen,
  input  logic [NUM_MASTERS*3-1:0]      m_arsize,
  input  logic [NUM_MASTERS*2-1:0]      m_arburst,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [1:0]                    m_rresp,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_rlast,
  output logic [ID_W-1:0]               m_rid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS*ID_W-1:0]   m_awid,
  input  logic [NUM_MASTERS*8-1:0]      m_awlen,
  input  logic [NUM_MASTERS*3-1:0]      m_awsize,
  input  logic [NUM_MASTERS*2-1:0]      m_awburst,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]        m_wlast,
  output logic [NUM_MASTERS-1:0]        m_wready,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  output logic [1:0]                    m_bresp,
  output logic [ID_W-1:0]               m_bid,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  output logic                          s_arvalid,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic [ID_W-1:0]               s_arid,
  output logic [7:0]                    s_arlen,
  output logic [2:0]                    s_arsize,
  output logic [1:0]                    s_arburst,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic [1:0]                    s_rresp,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rlast,
  input  logic [ID_W-1:0]               s_rid,
  output logic                          s_rready,
  output logic                          s_awvalid,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic [ID_W-1:0]               s_awid,
  output logic [7:0]                    s_awlen,
  output logic [2:0]                    s_awsize,
  output logic [1:0]                    s_awburst,
  input  logic                          s_awready,
  output logic                          s_wvalid,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  output logic                          s_wlast,
  input  logic                          s_wready,
  input  logic                          s_bvalid,
  input  logic [1:0]                    s_bresp,
  input  logic [ID_W-1:0]               s_bid,
  output logic                          s_bready,
  output logic                          rd_busy,
  output logic                          wr_busy,
  output logic [GNT_W-1:0]              rd_grant,
  output logic [GNT_W-1:0]              wr_grant
);

  localparam int SW = DATA_W / 8;

  rd_state_t              rd_state_r;
  wr_state_t              wr_state_r;
  logic [GNT_W-1:0]       rd_grant_r;
  logic [GNT_W-1:0]       wr_grant_r;
  logic [GNT_W-1:0]       rd_ptr_r;
  logic [GNT_W-1:0]       wr_ptr_r;
  logic [GNT_W-1:0]       rd_ptr_next_s;
  logic [GNT_W-1:0]       wr_ptr_next_s;
  logic                   rd_pick_valid_s;
  logic                   wr_pick_valid_s;
  logic [GNT_W-1:0]       rd_pick_idx_s;
  logic [GNT_W-1:0]       wr_pick_idx_s;
  logic [NUM_MASTERS-1:0] rd_oh_s;
  logic [NUM_MASTERS-1:0] wr_oh_s;
  logic                   ar_phase_s;
  logic                   r_phase_s;
  logic                   aw_phase_s;
  logic                   w_phase_s;
  logic                   b_phase_s;

  axi_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .GNT_W      (GNT_W)
  ) u_rd_pick (
    .req  (m_arvalid),
    .ptr  (rd_ptr_r),
    .valid(rd_pick_valid_s),
    .idx  (rd_pick_idx_s)
  );

  axi_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .GNT_W      (GNT_W)
  ) u_wr_pick (
    .req  (m_awvalid),
    .ptr  (wr_ptr_r),
    .valid(wr_pick_valid_s),
    .idx  (wr_pick_idx_s)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign rd_ptr_next_s = '0;
  assign wr_ptr_next_s = '0;
`else
  assign rd_ptr_next_s = GNT_W'(rr_next(32'(rd_grant_r), 32'(NUM_MASTERS)));
  assign wr_ptr_next_s = GNT_W'(rr_next(32'(wr_grant_r), 32'(NUM_MASTERS)));
`endif

  // Read path: grant, address handshake, data burst until rlast
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      rd_grant_r <= '0;
      rd_ptr_r   <= '0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (rd_pick_valid_s) begin
            rd_grant_r <= rd_pick_idx_s;
            rd_state_r <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (s_arvalid && s_arready) rd_state_r <= R_DATA;
        end
        R_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            rd_state_r <= R_IDLE;
            rd_ptr_r   <= rd_ptr_next_s;
          end
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Write path: grant, address, data until wlast, then a single B response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      wr_grant_r <= '0;
      wr_ptr_r   <= '0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (wr_pick_valid_s) begin
            wr_grant_r <= wr_pick_idx_s;
            wr_state_r <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (s_awvalid && s_awready) wr_state_r <= W_DATA;
        end
        W_DATA: begin
          if (s_wvalid && s_wready && s_wlast) wr_state_r <= W_RESP;
        end
        W_RESP: begin
          if (s_bvalid && s_bready) begin
            wr_state_r <= W_IDLE;
            wr_ptr_r   <= wr_ptr_next_s;
          end
        end
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  assign rd_oh_s    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << rd_grant_r;
  assign wr_oh_s    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << wr_grant_r;
  assign ar_phase_s = (rd_state_r == R_ADDR);
  assign r_phase_s  = (rd_state_r == R_DATA);
  assign aw_phase_s = (wr_state_r == W_ADDR);
  assign w_phase_s  = (wr_state_r == W_DATA);
  assign b_phase_s  = (wr_state_r == W_RESP);

  assign s_arvalid = ar_phase_s & m_arvalid[rd_grant_r];
  assign s_araddr  = m_araddr[rd_grant_r*ADDR_W +: ADDR_W];
  assign s_arid    = m_arid[rd_grant_r*ID_W +: ID_W];
  assign s_arlen   = m_arlen[rd_grant_r*8 +: 8];
  assign s_arsize  = m_arsize[rd_grant_r*3 +: 3];
  assign s_arburst = m_arburst[rd_grant_r*2 +: 2];
  assign m_arready = {NUM_MASTERS{ar_phase_s & s_arready}} & rd_oh_s;

  // Response payload is broadcast; only the granted master sees valid
  assign m_rvalid = {NUM_MASTERS{r_phase_s & s_rvalid}} & rd_oh_s;
  assign s_rready = r_phase_s & m_rready[rd_grant_r];
  assign m_rresp  = s_rresp;
  assign m_rdata  = s_rdata;
  assign m_rlast  = s_rlast;
  assign m_rid    = s_rid;

  assign s_awvalid = aw_phase_s & m_awvalid[wr_grant_r];
  assign s_awaddr  = m_awaddr[wr_grant_r*ADDR_W +: ADDR_W];
  assign s_awid    = m_awid[wr_grant_r*ID_W +: ID_W];
  assign s_awlen   = m_awlen[wr_grant_r*8 +: 8];
  assign s_awsize  = m_awsize[wr_grant_r*3 +: 3];
  assign s_awburst = m_awburst[wr_grant_r*2 +: 2];
  assign m_awready = {NUM_MASTERS{aw_phase_s & s_awready}} & wr_oh_s;

  assign s_wvalid = w_phase_s & m_wvalid[wr_grant_r];
  assign s_wdata  = m_wdata[wr_grant_r*DATA_W +: DATA_W];
  assign s_wstrb  = m_wstrb[wr_grant_r*SW +: SW];
  assign s_wlast  = m_wlast[wr_grant_r];
  assign m_wready = {NUM_MASTERS{w_phase_s & s_wready}} & wr_oh_s;

  assign m_bvalid = {NUM_MASTERS{b_phase_s & s_bvalid}} & wr_oh_s;
  assign s_bready = b_phase_s & m_bready[wr_grant_r];
  assign m_bresp  = s_bresp;
  assign m_bid    = s_bid;

  assign rd_busy  = (rd_state_r != R_IDLE);
  assign wr_busy  = (wr_state_r != W_IDLE);
  assign rd_grant = rd_grant_r;
  assign wr_grant = wr_grant_r;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter (N=2); ordering expectations follow ARB_FIXED_PRIO_EN.
module tb_axi_rr_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N*IW-1:0] m_arid, m_awid;
  logic [N*8-1:0] m_arlen, m_awlen;
  logic [N*3-1:0] m_arsize, m_awsize;
  logic [N*2-1:0] m_arburst, m_awburst;
  logic [1:0] m_rresp, m_bresp;
  logic [DW-1:0] m_rdata;
  logic m_rlast;
  logic [IW-1:0] m_rid, m_bid;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [N*DW-1:0] m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [IW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [7:0] s_arlen, s_awlen;
  logic [2:0] s_arsize, s_awsize;
  logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
  logic [DW-1:0] s_rdata, s_wdata;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [DW/8-1:0] s_wstrb;
  logic rd_busy, wr_busy;
  logic [0:0] rd_grant, wr_grant;

  int nvec = 0;
  int nerr = 0;

  axi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
    .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = '0; s_rlast = 1'b0; s_rid = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00; s_bid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m_arvalid = 2'b11; m_awvalid = 2'b11; s_rvalid = 1'b1; s_bvalid = 1'b1;
    s_arready = 1'b1; s_awready = 1'b1; m_rready = 2'b11; m_bready = 2'b11;
    step();
    nvec++; if (rd_busy !== 1'b0 || wr_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got rd=%b wr=%b, want 0 0", rd_busy, wr_busy); end
    nvec++; if (rd_grant !== 1'b0 || wr_grant !== 1'b0) begin nerr++; $display("FAIL reset_grant: got rd=%0d wr=%0d, want 0 0", rd_grant, wr_grant); end
    nvec++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin nerr++; $display("FAIL reset_s_valid_ready: got %b, want 00000", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}); end
    nvec++; if ({m_arready, m_awready, m_wready, m_rvalid, m_bvalid} !== 10'b0) begin nerr++; $display("FAIL reset_m_valid_ready: got %b, want 0", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}); end
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single_read();
    do_reset();
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h3000_0000; m_arlen[7:0] = 8'd0; s_arready = 1'b1;
    #1;
    nvec++; if (s_arvalid !== 1'b0) begin nerr++; $display("FAIL single_idle_arvalid: got %b, want 0", s_arvalid); end
    step();
    nvec++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0000) begin nerr++; $display("FAIL single_ar_fwd: got v=%b a=%h, want 1 30000000", s_arvalid, s_araddr); end
    nvec++; if (m_arready !== 2'b01 || rd_grant !== 1'b0) begin nerr++; $display("FAIL single_arready: got rdy=%b g=%0d, want 01 0", m_arready, rd_grant); end
    step();
    m_arvalid = 2'b00;
    s_rvalid = 1'b1; s_rdata = 64'h0000_0000_0000_1234; s_rlast = 1'b1; m_rready = 2'b11;
    #1;
    nvec++; if (m_rvalid !== 2'b01 || m_rdata !== 64'h1234 || s_rready !== 1'b1) begin nerr++; $display("FAIL single_rdata: got v=%b d=%h rr=%b, want 01 1234 1", m_rvalid, m_rdata, s_rready); end
    step();
    s_rvalid = 1'b0;
    #1;
    nvec++; if (rd_busy !== 1'b0) begin nerr++; $display("FAIL single_done: got busy=%b, want 0", rd_busy); end
  endtask

  task automatic test_rr_order();
    int exp_g [4];
    int cnt;
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    m_arvalid = 2'b11; s_arready = 1'b1; m_rready = 2'b11;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h55;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (s_arvalid !== 1'b1 && cnt < 10) begin
        step();
        cnt++;
      end
      nvec++; if (cnt >= 10) begin nerr++; $display("FAIL rr_wait_%0d: got no s_arvalid, want one within 10 cycles", k); end
      nvec++; if (rd_grant !== 1'(exp_g[k])) begin nerr++; $display("FAIL rr_grant_%0d: got %0d, want %0d", k, rd_grant, exp_g[k]); end
      step();
      nvec++; if (m_rvalid !== (2'b01 << exp_g[k])) begin nerr++; $display("FAIL rr_rvalid_%0d: got %b, want master %0d", k, m_rvalid, exp_g[k]); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_burst_read();
    do_reset();
    m_arvalid = 2'b10; m_arid[7:4] = 4'h5; m_arlen[15:8] = 8'd3; m_arburst[3:2] = BURST_INCR;
    m_arlen[7:0] = 8'd0; s_arready = 1'b1; m_rready = 2'b11;
    step();
    m_arvalid = 2'b11;
    #1;
    nvec++; if (rd_grant !== 1'b1 || m_arready !== 2'b10) begin nerr++; $display("FAIL burst_grant1: got g=%0d rdy=%b, want 1 10", rd_grant, m_arready); end
    nvec++; if (s_arlen !== 8'd3 || s_arburst !== BURST_INCR || s_arid !== 4'h5) begin nerr++; $display("FAIL burst_ar_payload: got len=%0d b=%0d id=%h, want 3 1 5", s_arlen, s_arburst, s_arid); end
    step();
    m_arvalid = 2'b01;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 64'h100 + 64'(b); s_rlast = (b == 3);
      #1;
      nvec++; if (m_rvalid !== 2'b10 || m_rdata !== (64'h100 + 64'(b))) begin nerr++; $display("FAIL burst_beat_%0d: got v=%b d=%h, want 10 %h", b, m_rvalid, m_rdata, 64'h100 + 64'(b)); end
      nvec++; if (m_arready !== 2'b00) begin nerr++; $display("FAIL burst_holdoff_%0d: got arready=%b, want 00", b, m_arready); end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    nvec++; if (rd_busy !== 1'b0 || s_arvalid !== 1'b0) begin nerr++; $display("FAIL burst_idle: got busy=%b arv=%b, want 0 0", rd_busy, s_arvalid); end
    step();
    nvec++; if (rd_grant !== 1'b0 || m_arready !== 2'b01) begin nerr++; $display("FAIL burst_next_grant: got g=%0d rdy=%b, want 0 01", rd_grant, m_arready); end
    step();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic test_concurrent_rw();
    do_reset();
    m_awvalid = 2'b10; m_awaddr[63:32] = 32'h0200_0000; m_awlen[15:8] = 8'd0;
    m_wvalid = 2'b10; m_wdata[127:64] = 64'h0000_0000_dead_beef; m_wstrb[15:8] = 8'h0F; m_wlast = 2'b10;
    s_awready = 1'b1; s_wready = 1'b1;
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h1000_0040; s_arready = 1'b1; m_rready = 2'b01;
    #1;
    nvec++; if (m_wready !== 2'b00 || s_wvalid !== 1'b0) begin nerr++; $display("FAIL rw_w_early: got wready=%b swv=%b, want 00 0", m_wready, s_wvalid); end
    step();
    nvec++; if (wr_grant !== 1'b1 || rd_grant !== 1'b0 || s_awaddr !== 32'h0200_0000 || s_awvalid !== 1'b1) begin nerr++; $display("FAIL rw_addr: got wg=%0d rg=%0d awa=%h awv=%b, want 1 0 02000000 1", wr_grant, rd_grant, s_awaddr, s_awvalid); end
    step();
    m_arvalid = 2'b00; m_awvalid = 2'b00;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h77;
    #1;
    nvec++; if (s_wvalid !== 1'b1 || s_wdata !== 64'hdead_beef || s_wstrb !== 8'h0F || m_wready !== 2'b10) begin nerr++; $display("FAIL rw_wdata: got v=%b d=%h s=%h rdy=%b, want 1 deadbeef 0f 10", s_wvalid, s_wdata, s_wstrb, m_wready); end
    nvec++; if ((rd_busy & wr_busy) !== 1'b1 || m_rvalid !== 2'b01) begin nerr++; $display("FAIL rw_overlap: got rb=%b wb=%b rv=%b, want 1 1 01", rd_busy, wr_busy, m_rvalid); end
    step();
    m_wvalid = 2'b00; s_rvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = RESP_OKAY; m_bready = 2'b10;
    #1;
    nvec++; if (m_bvalid !== 2'b10 || m_bresp !== RESP_OKAY || s_bready !== 1'b1) begin nerr++; $display("FAIL rw_bresp: got bv=%b br=%0d sbr=%b, want 10 0 1", m_bvalid, m_bresp, s_bready); end
    nvec++; if (rd_busy !== 1'b0 || wr_busy !== 1'b1) begin nerr++; $display("FAIL rw_resp_busy: got rb=%b wb=%b, want 0 1", rd_busy, wr_busy); end
    step();
    s_bvalid = 1'b0;
    #1;
    nvec++; if (wr_busy !== 1'b0 || m_bvalid !== 2'b00) begin nerr++; $display("FAIL rw_done: got wb=%b bv=%b, want 0 00", wr_busy, m_bvalid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m_arvalid = 2'b01; m_arlen[7:0] = 8'd3; s_arready = 1'b1; m_rready = 2'b01;
    step();
    step();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b0;
    step();
    step();
    nvec++; if (m_rvalid !== 2'b01 || s_rready !== 1'b1) begin nerr++; $display("FAIL mid_before: got rv=%b rr=%b, want 01 1", m_rvalid, s_rready); end
    reset = 1'b1;
    #1;
    nvec++; if (s_rready !== 1'b0 || m_rvalid !== 2'b00 || rd_busy !== 1'b0) begin nerr++; $display("FAIL mid_async: got rr=%b rv=%b busy=%b, want 0 00 0", s_rready, m_rvalid, rd_busy); end
    #2;
    reset = 1'b0;
    clear_inputs();
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h3000_0100; s_arready = 1'b1; m_rready = 2'b01;
    step();
    nvec++; if (rd_grant !== 1'b0 || s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0100) begin nerr++; $display("FAIL mid_restart_ar: got g=%0d v=%b a=%h, want 0 1 30000100", rd_grant, s_arvalid, s_araddr); end
    step();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    nvec++; if (m_rvalid !== 2'b01) begin nerr++; $display("FAIL mid_restart_r: got %b, want 01", m_rvalid); end
    step();
    nvec++; if (rd_busy !== 1'b0) begin nerr++; $display("FAIL mid_restart_done: got %b, want 0", rd_busy); end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_order();
    test_burst_read();
    test_concurrent_rw();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
